// File: rtl/glitch_ctrl.sv
// UART-commanded fault-injection controller: a 5-byte packet parser programs delay/width
// registers and arms a single-shot glitch FSM that fires a pulse after a trigger edge.
module glitch_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  input  logic       trigger,
  output logic       glitch_out,
  output logic       armed,
  output logic       busy,
  output logic       ack_dv,
  output logic [7:0] ack_byte
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  localparam logic [7:0] OP_DELAY  = 8'h01;
  localparam logic [7:0] OP_WIDTH  = 8'h02;
  localparam logic [7:0] OP_ARM    = 8'h03;
  localparam logic [7:0] OP_ABORT  = 8'h04;

  localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {P_SYNC, P_OP, P_ARGH, P_ARGL, P_CSUM} p_state_t;
  typedef enum logic [1:0] {G_IDLE, G_ARMED, G_DELAY, G_PULSE} g_state_t;

  function automatic logic [CNT_W-1:0] fit_cnt(input logic [15:0] v);
    return CNT_W'(v);
  endfunction

  p_state_t         p_q, p_nx;
  logic [TO_W-1:0]  to_q, to_nx;
  logic [7:0]       op_q, arg_hi_q, arg_lo_q;

  g_state_t         g_q, g_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [CNT_W-1:0] delay_q, width_q;
  logic             trig_p1, trig_edge;
  logic             glitch_nx, armed_nx, busy_nx;

  logic             cmd_vld_p0, csum_ok_p0, op_ok_p0, ack_ok_p0;
  logic             wr_delay_p0, wr_width_p0, arm_p0, abort_p0;

  // ---- parser: state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q  <= P_SYNC;
      to_q <= '0;
    end else begin
      p_q  <= p_nx;
      to_q <= to_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_dv) begin
      case (p_q)
        P_OP:    op_q     <= rx_byte;
        P_ARGH:  arg_hi_q <= rx_byte;
        P_ARGL:  arg_lo_q <= rx_byte;
        default: ;
      endcase
    end
  end

  // ---- parser: next state and inter-byte timeout ----
  always_comb begin
    p_nx  = p_q;
    to_nx = to_q;
    if (rx_dv) begin
      to_nx = '0;
      case (p_q)
        P_SYNC:  if (rx_byte == SYNC_BYTE) p_nx = P_OP;
        P_OP:    p_nx = P_ARGH;
        P_ARGH:  p_nx = P_ARGL;
        P_ARGL:  p_nx = P_CSUM;
        default: p_nx = P_SYNC;
      endcase
    end else if (p_q != P_SYNC) begin
      if (to_q == TO_LAST) begin
        p_nx  = P_SYNC;
        to_nx = '0;
      end else begin
        to_nx = to_q + TO_ONE;
      end
    end
  end

  // ---- p0: command decode on the checksum byte ----
  always_comb begin
    cmd_vld_p0 = rx_dv && (p_q == P_CSUM);
    csum_ok_p0 = (rx_byte == (op_q ^ arg_hi_q ^ arg_lo_q));
    case (op_q)
      OP_DELAY, OP_WIDTH, OP_ARM: op_ok_p0 = !((g_q == G_DELAY) || (g_q == G_PULSE));
      OP_ABORT:                   op_ok_p0 = 1'b1;
      default:                    op_ok_p0 = 1'b0;
    endcase
    ack_ok_p0   = cmd_vld_p0 && csum_ok_p0 && op_ok_p0;
    wr_delay_p0 = ack_ok_p0 && (op_q == OP_DELAY);
    wr_width_p0 = ack_ok_p0 && (op_q == OP_WIDTH);
    arm_p0      = ack_ok_p0 && (op_q == OP_ARM);
    abort_p0    = ack_ok_p0 && (op_q == OP_ABORT);
  end

  // ---- p1: response strobe and register writes ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_dv   <= 1'b0;
      ack_byte <= 8'h00;
      delay_q  <= '0;
      width_q  <= CNT_ONE;
    end else begin
      ack_dv <= cmd_vld_p0;
      if (cmd_vld_p0) ack_byte <= ack_ok_p0 ? ACK_BYTE : NAK_BYTE;
      if (wr_delay_p0) delay_q <= fit_cnt({arg_hi_q, arg_lo_q});
      if (wr_width_p0) width_q <= fit_cnt({arg_hi_q, arg_lo_q});
    end
  end

  assign trig_edge = trigger && !trig_p1;

  // ---- glitch FSM: state register with registered outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_q        <= G_IDLE;
      cnt_q      <= '0;
      trig_p1    <= 1'b0;
      glitch_out <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      g_q        <= g_nx;
      cnt_q      <= cnt_nx;
      trig_p1    <= trigger;
      glitch_out <= glitch_nx;
      armed      <= armed_nx;
      busy       <= busy_nx;
    end
  end

  // Abort outranks a same-cycle trigger edge and any count completion.
  always_comb begin
    g_nx   = g_q;
    cnt_nx = cnt_q;
    case (g_q)
      G_IDLE: if (arm_p0) g_nx = G_ARMED;
      G_ARMED: begin
        if (abort_p0) begin
          g_nx = G_IDLE;
        end else if (trig_edge) begin
          g_nx   = G_DELAY;
          cnt_nx = delay_q;
        end
      end
      G_DELAY: begin
        if (abort_p0) begin
          g_nx = G_IDLE;
        end else if (cnt_q == '0) begin
          if (width_q == '0) begin
            g_nx = G_IDLE;
          end else begin
            g_nx   = G_PULSE;
            cnt_nx = width_q - CNT_ONE;
          end
        end else begin
          cnt_nx = cnt_q - CNT_ONE;
        end
      end
      default: begin
        if (abort_p0 || (cnt_q == '0)) g_nx = G_IDLE;
        else                           cnt_nx = cnt_q - CNT_ONE;
      end
    endcase
  end

  always_comb begin
    armed_nx  = (g_nx == G_ARMED);
    busy_nx   = (g_nx == G_DELAY) || (g_nx == G_PULSE);
    glitch_nx = (g_nx == G_PULSE);
  end

endmodule

// File: tb/tb_glitch_ctrl.sv
// Directed bench for glitch_ctrl: command packets, pulse timing, abort, timeout and reset.
module tb_glitch_ctrl;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       trigger = 1'b0;
  logic       glitch_out, armed, busy, ack_dv;
  logic [7:0] ack_byte;

  int         n_total = 0;
  int         n_bad = 0;
  int         ack_cnt = 0;
  logic [7:0] last_ack = 8'h00;
  int         glitch_cycles = 0;

  glitch_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte), .trigger(trigger),
    .glitch_out(glitch_out), .armed(armed), .busy(busy),
    .ack_dv(ack_dv), .ack_byte(ack_byte)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ack_dv) begin
      ack_cnt  <= ack_cnt + 1;
      last_ack <= ack_byte;
    end
    if (glitch_out) glitch_cycles <= glitch_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv   = 1'b0;
  endtask

  task automatic send_pkt(input string tag, input logic [7:0] op, input logic [7:0] ah,
                          input logic [7:0] al, input logic [7:0] cs, input logic [7:0] exp);
    int n0;
    n0 = ack_cnt;
    send_byte(8'hA5); send_byte(op); send_byte(ah); send_byte(al); send_byte(cs);
    @(negedge clk); @(negedge clk); #1;
    chk({tag, "_nack"}, ack_cnt - n0, 1);
    chk({tag, "_byte"}, {24'h0, last_ack}, {24'h0, exp});
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input string tag, input logic [7:0] op, input logic [7:0] ah,
                          input logic [7:0] al, input logic [7:0] exp);
    send_pkt(tag, op, ah, al, op ^ ah ^ al, exp);
  endtask

  // bit i of gp/bp holds glitch_out/busy i cycles after the edge-sampling clock
  task automatic fire(input int n, output logic [31:0] gp, output logic [31:0] bp,
                      output logic ae);
    gp = '0;
    bp = '0;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    ae    = armed;
    gp[0] = glitch_out;
    bp[0] = busy;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      gp[i] = glitch_out;
      bp[i] = busy;
    end
  endtask

  initial begin
    logic [31:0] gp, bp;
    logic        ae;
    int          n0, g0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_glitch", {31'h0, glitch_out}, 0);
    chk("rst_armed", {31'h0, armed}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_ackdv", {31'h0, ack_dv}, 0);
    chk("rst_ackbyte", {24'h0, ack_byte}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // reset defaults delay=0 width=1
    send_cmd("def_arm", 8'h03, 8'h00, 8'h00, ACK);
    chk("def_armed", {31'h0, armed}, 1);
    fire(12, gp, bp, ae);
    chk("def_gpat", gp, 32'h2);
    chk("def_bpat", bp, 32'h3);

    // delay=5 width=3 pulse
    send_cmd("d5", 8'h01, 8'h00, 8'h05, ACK);
    send_cmd("w3", 8'h02, 8'h00, 8'h03, ACK);
    send_cmd("arm1", 8'h03, 8'h00, 8'h00, ACK);
    chk("arm1_armed", {31'h0, armed}, 1);
    fire(12, gp, bp, ae);
    chk("p1_armed_edge", {31'h0, ae}, 0);
    chk("p1_gpat", gp, 32'h1C0);
    chk("p1_bpat", bp, 32'h1FF);

    // bad checksum is NAKed and leaves delay at 5
    send_pkt("badcs", 8'h01, 8'h00, 8'h05, 8'h05, NAK);
    send_cmd("arm2", 8'h03, 8'h00, 8'h00, ACK);
    fire(12, gp, bp, ae);
    chk("p2_gpat", gp, 32'h1C0);

    // partial packet times out silently
    n0 = ack_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    repeat (TIMEOUT + 1) @(posedge clk);
    #1;
    chk("to_noresp", ack_cnt - n0, 0);
    send_cmd("w4", 8'h02, 8'h00, 8'h04, ACK);
    send_cmd("arm3", 8'h03, 8'h00, 8'h00, ACK);
    fire(12, gp, bp, ae);
    chk("p3_gpat", gp, 32'h3C0);
    chk("p3_bpat", bp, 32'h3FF);

    // unknown op, abort in IDLE, re-arm while armed
    send_cmd("badop", 8'h07, 8'h00, 8'h00, NAK);
    send_cmd("abort_idle", 8'h04, 8'h00, 8'h00, ACK);
    chk("abort_idle_armed", {31'h0, armed}, 0);
    send_cmd("arm4", 8'h03, 8'h00, 8'h00, ACK);
    send_cmd("arm4b", 8'h03, 8'h00, 8'h00, ACK);
    chk("rearm_armed", {31'h0, armed}, 1);
    send_cmd("abort_arm", 8'h04, 8'h00, 8'h00, ACK);
    chk("abort_arm_armed", {31'h0, armed}, 0);

    // abort in the middle of a long delay
    send_cmd("d100", 8'h01, 8'h00, 8'h64, ACK);
    send_cmd("w10", 8'h02, 8'h00, 8'h0A, ACK);
    send_cmd("arm5", 8'h03, 8'h00, 8'h00, ACK);
    g0 = glitch_cycles;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("mid_busy", {31'h0, busy}, 1);
    send_cmd("abort_dly", 8'h04, 8'h00, 8'h00, ACK);
    chk("abort_busy", {31'h0, busy}, 0);
    chk("abort_armed", {31'h0, armed}, 0);
    repeat (150) @(posedge clk);
    #1;
    chk("abort_noglitch", glitch_cycles - g0, 0);
    fire(12, gp, bp, ae);
    chk("idle_trig_gpat", gp, 32'h0);
    chk("idle_trig_bpat", bp, 32'h0);

    // width write while busy is NAKed; pulse keeps width 10
    send_cmd("d3", 8'h01, 8'h00, 8'h03, ACK);
    send_cmd("arm6", 8'h03, 8'h00, 8'h00, ACK);
    g0 = glitch_cycles;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    send_cmd("busy_w", 8'h02, 8'h00, 8'h01, NAK);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_width", glitch_cycles - g0, 10);
    chk("busy_done", {31'h0, busy}, 0);

    // delay=0 width=0: no pulse, back to IDLE
    send_cmd("d0", 8'h01, 8'h00, 8'h00, ACK);
    send_cmd("w0", 8'h02, 8'h00, 8'h00, ACK);
    send_cmd("arm7", 8'h03, 8'h00, 8'h00, ACK);
    fire(6, gp, bp, ae);
    chk("w0_gpat", gp, 32'h0);
    chk("w0_bpat", bp, 32'h1);
    chk("w0_armed", {31'h0, armed}, 0);

    // asynchronous reset during pulse
    send_cmd("w20", 8'h02, 8'h00, 8'h14, ACK);
    send_cmd("arm8", 8'h03, 8'h00, 8'h00, ACK);
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_glitch", {31'h0, glitch_out}, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_glitch", {31'h0, glitch_out}, 0);
    chk("async_busy", {31'h0, busy}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_armed", {31'h0, armed}, 0);
    send_cmd("post_rst", 8'h02, 8'h00, 8'h01, ACK);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/glitch_ctrl.md
GLITCH_CTRL -- requirements
Module: glitch_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the delay and width registers and counters.
REQ-002 SHALL have parameter TIMEOUT, default 1000, the maximum number of idle clock cycles allowed between bytes of one packet.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port rx_dv, input, 1 bit: one-cycle strobe from the UART receiver, meaning rx_byte is valid.
REQ-006 SHALL have port rx_byte, input, 8 bits: received UART byte.
REQ-007 SHALL have port trigger, input, 1 bit: target trigger, already synchronous to clk.
REQ-008 SHALL have port glitch_out, output, 1 bit: glitch pulse to the glitcher.
REQ-009 SHALL have port armed, output, 1 bit: high while the glitch FSM is in ARMED.
REQ-010 SHALL have port busy, output, 1 bit: high while the glitch FSM is in DELAY or PULSE.
REQ-011 SHALL have port ack_dv, output, 1 bit: one-cycle strobe to the UART transmitter.
REQ-012 SHALL have port ack_byte, output, 8 bits: response byte.

Function
REQ-013 Packet format SHALL be 5 bytes, sent as 0xA5 (sync), then OP, then ARG_HI, then ARG_LO, then CSUM.
REQ-014 CSUM SHALL equal OP ^ ARG_HI ^ ARG_LO.
REQ-015 The parser FSM SHALL have states SYNC, OP, ARGH, ARGL and CSUM, and SHALL advance one state per rx_dv.
REQ-016 In SYNC, any byte other than 0xA5 SHALL be discarded silently.
REQ-017 In any state other than SYNC, if TIMEOUT cycles pass without rx_dv, the parser SHALL return to SYNC with no response.
REQ-018 The timeout counter SHALL restart on every rx_dv.
REQ-019 OP 0x01 SHALL set the delay register to {ARG_HI,ARG_LO}; OP 0x02 SHALL set the width register to the same value.
REQ-020 Register values SHALL be zero-extended or truncated to CNT_W bits.
REQ-021 OP 0x03 SHALL arm; OP 0x04 SHALL disarm and abort. For both, the argument SHALL be ignored.
REQ-022 When the CSUM byte arrives, in the cycle after it is accepted, ack_dv SHALL pulse for exactly 1 cycle.
REQ-023 ack_byte SHALL be 0x06 (ACK) on success and 0x15 (NAK) on a checksum mismatch, an unknown OP, or OP 0x01, 0x02 or 0x03 while busy=1.
REQ-024 A NAKed command SHALL have no effect.
REQ-025 The glitch FSM SHALL have states IDLE, ARMED, DELAY and PULSE.
REQ-026 Glitch FSM transitions SHALL be:
- IDLE->ARMED on an ACKed OP 0x03.
- ARMED->DELAY on a trigger rising edge (trigger=1 and previous-cycle trigger=0), loading the delay counter.
- DELAY->PULSE when the delay count is done.
- PULSE->IDLE when the width count is done.
REQ-027 glitch_out SHALL be high for exactly width cycles, starting delay+1 cycles after the cycle in which the trigger edge is sampled.
REQ-028 If delay=0, glitch_out SHALL rise in the cycle after the edge.
REQ-029 If width=0, glitch_out SHALL never assert, and the FSM SHALL return to IDLE.
REQ-030 The block SHALL be single-shot: after PULSE the FSM goes to IDLE, and re-arming requires a new OP 0x03.
REQ-031 An ACKed OP 0x04 in ARMED, DELAY or PULSE SHALL force IDLE and glitch_out=0 in the cycle after the ACK; in IDLE it is ACKed as a no-op.
REQ-032 OP 0x03 while already ARMED SHALL be ACKed and SHALL leave the FSM in ARMED.
REQ-033 A trigger edge that arrives in the same cycle as an ACKed OP 0x04 SHALL be ignored.
REQ-034 Trigger edges while in IDLE, DELAY or PULSE SHALL be ignored.
REQ-035 glitch_out, armed and busy SHALL be registered outputs.
REQ-036 Register writes SHALL take effect on the next arm; the current DELAY or PULSE is unaffected, since such writes are NAKed anyway.

Reset
REQ-037 While rst=0, asynchronously: parser in SYNC, glitch FSM in IDLE, delay=0, width=1, and all counters, glitch_out, armed, busy, ack_dv and ack_byte set to 0.
REQ-038 If reset is asserted mid-packet or mid-pulse, glitch_out SHALL drop immediately.
REQ-039 After release, the first valid packet SHALL be accepted normally.

Verification
REQ-040 Send A5 01 00 05 04, then A5 02 00 03 01, then A5 03 00 00 03, then pulse trigger -> three ACKs (0x06); glitch_out high for 3 cycles, starting 6 cycles after the edge cycle; armed drops on the edge; busy high through the pulse.
REQ-041 Send A5 01 00 05 05 (bad CSUM) -> one NAK (0x15); delay register unchanged.
REQ-042 Send A5 01 00, then wait TIMEOUT+1 cycles, then send A5 02 00 04 06 -> no response to the partial packet; the second packet is ACKed and width=4.
REQ-043 Set delay=100 width=10, arm, trigger, and at delay cycle 50 send A5 04 00 00 04 -> ACK; glitch_out never asserts; FSM back in IDLE; a later trigger produces no pulse.
REQ-044 While busy, send OP 0x02 -> NAK, and the current pulse width is unchanged.
REQ-045 Set delay=0 width=0 and trigger -> no pulse; the FSM returns to IDLE.
REQ-046 Assert rst during PULSE -> glitch_out=0 asynchronously; after release, armed=0.
